// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg: register map and widths shared by the interrupt aggregator files
package irq_aggregator_pkg;
  localparam int IRQ_ID_W = 5;
  localparam int IRQ_MAX = 32;
  localparam logic [7:0] IRQ_REG_PENDING = 8'h00;
  localparam logic [7:0] IRQ_REG_ENABLE = 8'h04;
  localparam logic [7:0] IRQ_REG_ACTIVE = 8'h08;
  localparam logic [7:0] IRQ_REG_CLAIM = 8'h0C;
  localparam logic [7:0] IRQ_REG_FORCE = 8'h10;
  localparam logic [7:0] IRQ_REG_EDGE = 8'h14;
endpackage

// File: rtl/irq_aggregator_if.sv
// irq_aggregator_if: peripheral control bus (request held until done, one-cycle done pulse)
interface irq_aggregator_if;
  logic wr;
  logic rd;
  logic [7:0] addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic done;
  modport master(output wr, rd, addr, wdat, input rdat, done);
  modport slave(input wr, rd, addr, wdat, output rdat, done);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-set-bit encoder; id is 0 when no request is set
module irq_prio_enc
  import irq_aggregator_pkg::*;
(
  input  logic [IRQ_MAX-1:0]  req,
  output logic [IRQ_ID_W-1:0] id,
  output logic                valid
);
  always_comb begin
    id = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) if (req[i]) id = IRQ_ID_W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: latches source interrupts into PENDING, masks with ENABLE, drives a registered CPU irq
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic                clk,
  input  logic                resetn,
  irq_aggregator_if.slave     ctrl,
  input  logic [NUM_IRQ-1:0]  irq_in,
  output logic                irq_out,
  output logic [IRQ_ID_W-1:0] irq_id
);
  logic [NUM_IRQ-1:0] pending, enable, edge_mode, irq_q, active, set, clr, frc;
  logic [IRQ_ID_W-1:0] cur_id;
  logic any, acc, wr, rd, claim;
  logic [31:0] rd_val;
  logic unused_wdat;
  assign acc = (ctrl.wr | ctrl.rd) & ~ctrl.done;
  assign wr = acc & ctrl.wr;
  assign rd = acc & ctrl.rd & ~ctrl.wr;
  assign active = pending & enable;
  assign unused_wdat = ^ctrl.wdat;
  irq_prio_enc u_enc (.req(IRQ_MAX'(active)), .id(cur_id), .valid(any));
  // edge lines only fire on a 0->1 transition; level lines fire whenever high
  assign set = irq_in & ~(edge_mode & irq_q);
  assign claim = rd && ctrl.addr == IRQ_REG_CLAIM && any;
  assign clr = (wr && ctrl.addr == IRQ_REG_PENDING ? ctrl.wdat[NUM_IRQ-1:0] : '0) |
               (claim ? NUM_IRQ'(1) << cur_id : '0);
  assign frc = wr && ctrl.addr == IRQ_REG_FORCE ? ctrl.wdat[NUM_IRQ-1:0] : '0;
  always_comb begin
    rd_val = ctrl.addr == IRQ_REG_PENDING ? 32'(pending) :
             ctrl.addr == IRQ_REG_ENABLE  ? 32'(enable) :
             ctrl.addr == IRQ_REG_ACTIVE  ? 32'(active) :
             ctrl.addr == IRQ_REG_CLAIM   ? {any, 26'd0, cur_id} :
             ctrl.addr == IRQ_REG_EDGE    ? 32'(edge_mode) : '0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending <= '0;
      enable <= '0;
      edge_mode <= '0;
      irq_q <= '0;
      irq_out <= 1'b0;
      irq_id <= '0;
      ctrl.done <= 1'b0;
      ctrl.rdat <= '0;
    end else begin
      pending <= (pending & ~clr) | set | frc;
      if (wr && ctrl.addr == IRQ_REG_ENABLE) enable <= ctrl.wdat[NUM_IRQ-1:0];
      if (wr && ctrl.addr == IRQ_REG_EDGE) edge_mode <= ctrl.wdat[NUM_IRQ-1:0];
      irq_q <= irq_in;
      irq_out <= any;
      irq_id <= cur_id;
      ctrl.done <= acc;
      ctrl.rdat <= rd ? rd_val : '0;
    end
  end
endmodule
